// File: rtl/store_coalesce_buffer_pkg.sv
// rtl/store_coalesce_buffer_pkg.sv - shared constants, size encodings and mask helpers for the store buffer
package store_coalesce_buffer_pkg;

  localparam int CHUNK_BYTES = 16;
  localparam int CHUNK_OFF_W = 4;
  localparam int CHUNK_W     = CHUNK_BYTES * 8;
  localparam int ST_DATA_W   = 64;

  typedef enum logic [1:0] {
    SIZE_8BIT  = 2'b00,
    SIZE_16BIT = 2'b01,
    SIZE_32BIT = 2'b10,
    SIZE_64BIT = 2'b11
  } st_size_e;

  // Byte-enable pattern of a store sitting at chunk offset 0
  function automatic logic [CHUNK_BYTES-1:0] size_base_mask(input st_size_e size);
    logic [CHUNK_BYTES-1:0] mask;
    case (size)
      SIZE_8BIT:  mask = 16'h0001;
      SIZE_16BIT: mask = 16'h0003;
      SIZE_32BIT: mask = 16'h000F;
      default:    mask = 16'h00FF;
    endcase
    return mask;
  endfunction

  // Widen a per-byte enable into a per-bit mask over the whole chunk
  function automatic logic [CHUNK_W-1:0] expand_bsel(input logic [CHUNK_BYTES-1:0] bsel);
    logic [CHUNK_W-1:0] mask;
    for (int i = 0; i < CHUNK_BYTES; i++) begin
      mask[i*8 +: 8] = {8{bsel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/store_coalesce_buffer_if.sv
// rtl/store_coalesce_buffer_if.sv - LSU store port, data-array write port and load-check signals
interface store_coalesce_buffer_if
  import store_coalesce_buffer_pkg::*;
#(
  parameter int PADDR_W = 56
);

  logic                   st_valid;
  logic                   st_ready;
  logic [PADDR_W-1:0]     st_addr;
  logic [ST_DATA_W-1:0]   st_data;
  logic [1:0]             st_size;
  logic                   st_err;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [PADDR_W-1:0]     wr_addr;
  logic [CHUNK_W-1:0]     wr_data;
  logic [CHUNK_BYTES-1:0] wr_bsel;

  logic [PADDR_W-1:0]     ld_addr;
  logic                   ld_conflict;
  logic                   empty;

  // Environment side: LSU plus data array
  modport master (
    output st_valid, st_addr, st_data, st_size, wr_ready, ld_addr,
    input  st_ready, st_err, wr_valid, wr_addr, wr_data, wr_bsel, ld_conflict, empty
  );

  // Buffer side
  modport slave (
    input  st_valid, st_addr, st_data, st_size, wr_ready, ld_addr,
    output st_ready, st_err, wr_valid, wr_addr, wr_data, wr_bsel, ld_conflict, empty
  );

endinterface

// File: rtl/store_coalesce_buffer_chunk_align.sv
// rtl/store_coalesce_buffer_chunk_align.sv - places a store into its 128-bit chunk and flags misalignment
module store_chunk_align
  import store_coalesce_buffer_pkg::*;
(
  input  logic [CHUNK_OFF_W-1:0] offset,
  input  logic [ST_DATA_W-1:0]   st_data,
  input  st_size_e               st_size,
  output logic [CHUNK_W-1:0]     data,
  output logic [CHUNK_BYTES-1:0] bsel,
  output logic                   misaligned
);

  // Shift the LSB-justified bytes to their offset; naturally aligned sizes only
  always_comb begin
    data       = {{(CHUNK_W - ST_DATA_W){1'b0}}, st_data} << {offset, 3'b000};
    bsel       = size_base_mask(st_size) << offset;
    misaligned = 1'b0;
    case (st_size)
      SIZE_16BIT: misaligned = offset[0];
      SIZE_32BIT: misaligned = |offset[1:0];
      SIZE_64BIT: misaligned = |offset[2:0];
      default:    misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_coalesce_buffer.sv
// rtl/store_coalesce_buffer.sv - in-order coalescing store buffer in front of the L1D write port
module store_coalesce_buffer
  import store_coalesce_buffer_pkg::*;
#(
  parameter int PADDR_W = 56,
  parameter int DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  store_coalesce_buffer_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CADDR_W = PADDR_W - CHUNK_OFF_W;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CADDR_W-1:0]     ent_caddr [DEPTH];
  logic [CHUNK_W-1:0]     ent_data  [DEPTH];
  logic [CHUNK_BYTES-1:0] ent_bsel  [DEPTH];
  logic [DEPTH-1:0]       ent_valid;

  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W-1:0]       youngest;
  logic [CNT_W-1:0]       count;
  logic                   st_err_q;

  logic [CHUNK_W-1:0]     new_data;
  logic [CHUNK_BYTES-1:0] new_bsel;
  logic                   new_misaligned;
  logic [CHUNK_W-1:0]     merge_mask;

  logic [CADDR_W-1:0]     st_caddr;
  logic [CADDR_W-1:0]     ld_caddr;
  logic                   ld_offset_unused;
  logic                   ld_hit;

  logic                   push;
  logic                   accept;
  logic                   do_merge;
  logic                   do_alloc;
  logic                   do_pop;

  store_chunk_align u_align (
    .offset     (bus.st_addr[CHUNK_OFF_W-1:0]),
    .st_data    (bus.st_data),
    .st_size    (st_size_e'(bus.st_size)),
    .data       (new_data),
    .bsel       (new_bsel),
    .misaligned (new_misaligned)
  );

  assign st_caddr         = bus.st_addr[PADDR_W-1:CHUNK_OFF_W];
  assign ld_caddr         = bus.ld_addr[PADDR_W-1:CHUNK_OFF_W];
  assign ld_offset_unused = ^bus.ld_addr[CHUNK_OFF_W-1:0];

  // A full buffer refuses stores even if the head retires this cycle
  assign bus.st_ready = (count < CNT_FULL);
  assign bus.wr_valid = (count != '0);
  assign bus.empty    = (count == '0);
  assign bus.st_err   = st_err_q;
  assign bus.wr_addr  = {ent_caddr[head], {CHUNK_OFF_W{1'b0}}};
  assign bus.wr_data  = ent_data[head];
  assign bus.wr_bsel  = ent_bsel[head];
  assign bus.ld_conflict = ld_hit;

  // Decide this cycle's push/merge/allocate/pop; the head is never a merge target
  always_comb begin
    youngest   = tail - PTR_ONE;
    push       = bus.st_valid && bus.st_ready;
    accept     = push && !new_misaligned;
    do_merge   = accept && (count >= CNT_TWO) && (ent_caddr[youngest] == st_caddr);
    do_alloc   = accept && !do_merge;
    do_pop     = bus.wr_valid && bus.wr_ready;
    merge_mask = expand_bsel(new_bsel);
  end

  // Load check covers every live entry, including the one being presented
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_caddr[i] == ld_caddr)) begin
        ld_hit = 1'b1;
      end
    end
  end

  // Pointers, occupancy and the one-cycle misalignment pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= push && new_misaligned;
      if (do_alloc) begin
        tail <= tail + PTR_ONE;
      end
      if (do_pop) begin
        head <= head + PTR_ONE;
      end
      case ({do_alloc, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: allocate at tail, merge into youngest, retire at head (never the same slot)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_caddr[i] <= '0;
        ent_data[i]  <= '0;
        ent_bsel[i]  <= '0;
      end
    end else begin
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
      end
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_caddr[tail] <= st_caddr;
        ent_data[tail]  <= new_data;
        ent_bsel[tail]  <= new_bsel;
      end
      if (do_merge) begin
        ent_data[youngest] <= (ent_data[youngest] & ~merge_mask) | (new_data & merge_mask);
        ent_bsel[youngest] <= ent_bsel[youngest] | new_bsel;
      end
    end
  end

endmodule
